// File: rtl/simon_pkg.sv
// Shared sizing and state encoding for the Simon key-schedule / round sequencer.
package simon_pkg;

   localparam int N       = 16;
   localparam int M       = 4;
   localparam int T       = 32;
   localparam int COUNT_W = $clog2(T);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KLOAD = 3'd1,
      S_KEXP  = 3'd2,
      S_PLOAD = 3'd3,
      S_ROUND = 3'd4,
      S_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/simon_sched_ctrl.sv
// Sequencer for a Simon block cipher: optional key load/expansion, block load,
// T rounds (forward or reverse index), then a one-cycle done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, ready=1
// S_KLOAD | one cycle, load M key words, key_ok cleared
// S_KEXP  | T-M cycles, expand key words M..T-1
// S_PLOAD | one cycle, load the data block
// S_ROUND | T cycles, index 0..T-1 (encrypt) or T-1..0 (decrypt)
// S_DONE  | one cycle completion pulse
module simon_sched_ctrl
   import simon_pkg::*;
#(
   parameter int N = simon_pkg::N,
   parameter int M = simon_pkg::M,
   parameter int T = simon_pkg::T
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic                 start,
   input  logic                 enc_dec,
   input  logic                 new_key,
   input  logic                 abort,
   output logic                 ready,
   output logic                 kLd,
   output logic                 kExp,
   output logic                 pLd,
   output logic                 rnd_en,
   output logic                 dir,
   output logic [$clog2(T)-1:0] count,
   output logic                 done,
   output logic                 key_ok
);

   localparam int CW = $clog2(T);
   localparam logic [CW-1:0] CNT_FIRST_EXP = CW'(M);
   localparam logic [CW-1:0] CNT_LAST      = CW'(T - 1);

   generate
      if (N < 1 || M < 1 || M >= T) begin : g_bad_params
         $error("simon_sched_ctrl: need N>=1 and 1<=M<T");
      end
   endgenerate

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   count_nx;
   logic [CW-1:0]   round_last;
   logic            accept;

   assign accept     = (state == S_IDLE) && start && !abort;
   assign round_last = dir ? '0 : CNT_LAST;

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (accept) state_nx = (new_key || !key_ok) ? S_KLOAD : S_PLOAD;
         S_KLOAD: state_nx = S_KEXP;
         S_KEXP:  if (count == CNT_LAST) state_nx = S_PLOAD;
         S_PLOAD: state_nx = S_ROUND;
         S_ROUND: if (count == round_last) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      // abort pre-empts every busy state, including the final KEXP/ROUND cycle
      if (abort && state != S_IDLE) state_nx = S_IDLE;
   end

   always_comb begin
      count_nx = '0;
      unique case (state_nx)
         S_KEXP:  count_nx = (state == S_KEXP) ? count + 1'b1 : CNT_FIRST_EXP;
         S_ROUND: begin
            if (state == S_ROUND) count_nx = dir ? count - 1'b1 : count + 1'b1;
            else                  count_nx = dir ? CNT_LAST : '0;
         end
         default: count_nx = '0;
      endcase
   end

   always_ff @(posedge clk or posedge nReset) begin
      if (nReset) begin
         state  <= S_IDLE;
         count  <= '0;
         dir    <= 1'b0;
         key_ok <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         if (accept) dir <= enc_dec;
         if (state_nx == S_KLOAD)
            key_ok <= 1'b0;
         else if (state == S_KEXP && state_nx == S_PLOAD)
            key_ok <= 1'b1;
      end
   end

   // strobes are pure state decodes, so they are one-hot with each other
   assign ready  = (state == S_IDLE);
   assign kLd    = (state == S_KLOAD);
   assign kExp   = (state == S_KEXP);
   assign pLd    = (state == S_PLOAD);
   assign rnd_en = (state == S_ROUND);
   assign done   = (state == S_DONE);

endmodule

// File: tb/tb_simon_sched_ctrl.sv
// Scoreboard bench: each accepted operation queues its cycle-by-cycle output
// trace, which is popped and compared one cycle at a time.
module tb_simon_sched_ctrl;
   import simon_pkg::*;

   localparam int VW = 8 + COUNT_W;

   logic clk = 1'b0;
   logic nReset = 1'b1;
   logic start = 1'b0, enc_dec = 1'b0, new_key = 1'b0, abort = 1'b0;
   logic ready, kLd, kExp, pLd, rnd_en, dir, done, key_ok;
   logic [COUNT_W-1:0] count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat_exp = 0;
   logic m_key_ok = 1'b0;
   logic m_dir = 1'b0;
   logic [VW-1:0] exp_q[$];

   simon_sched_ctrl #(.N(N), .M(M), .T(T)) dut (
      .clk(clk), .nReset(nReset), .start(start), .enc_dec(enc_dec),
      .new_key(new_key), .abort(abort), .ready(ready), .kLd(kLd),
      .kExp(kExp), .pLd(pLd), .rnd_en(rnd_en), .dir(dir), .count(count),
      .done(done), .key_ok(key_ok)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [VW-1:0] vec(input logic r, input logic kl, input logic ke,
                                         input logic pl, input logic re, input logic dn,
                                         input logic d, input logic ko, input int cnt);
      logic [COUNT_W-1:0] c;
      c = COUNT_W'(cnt);
      return {r, kl, ke, pl, re, dn, d, ko, c};
   endfunction

   function automatic logic [VW-1:0] obs();
      return {ready, kLd, kExp, pLd, rnd_en, done, dir, key_ok, count};
   endfunction

   task automatic step();
      logic [VW-1:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("trace", 32'(obs()), 32'(e));
      end
      if (done) chk("latency", cyc, lat_exp);
   endtask

   task automatic push_idle();
      exp_q.push_back(vec(1, 0, 0, 0, 0, 0, m_dir, m_key_ok, 0));
   endtask

   task automatic push_op(input logic nk, input logic d);
      m_dir = d;
      if (nk || !m_key_ok) begin
         lat_exp = 2 * T - M + 3;
         m_key_ok = 1'b0;
         exp_q.push_back(vec(0, 1, 0, 0, 0, 0, d, 0, 0));
         for (int i = M; i < T; i++) exp_q.push_back(vec(0, 0, 1, 0, 0, 0, d, 0, i));
         m_key_ok = 1'b1;
      end else begin
         lat_exp = T + 2;
      end
      exp_q.push_back(vec(0, 0, 0, 1, 0, 0, d, 1, 0));
      for (int i = 0; i < T; i++)
         exp_q.push_back(vec(0, 0, 0, 0, 1, 0, d, 1, d ? T - 1 - i : i));
      exp_q.push_back(vec(0, 0, 0, 0, 0, 1, d, 1, 0));
      push_idle();
   endtask

   task automatic accept(input logic nk, input logic d);
      start = 1'b1; new_key = nk; enc_dec = d;
      push_op(nk, d);
      cyc = 0;
      step();
      start = 1'b0; new_key = 1'b0; enc_dec = 1'b0;
   endtask

   task automatic drain();
      for (int g = 0; g < 300 && exp_q.size() > 0; g++) step();
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      // reset state
      #2;
      chk("reset_state", 32'(obs()), 32'(vec(1, 0, 0, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
      nReset = 1'b0;
      push_idle();
      step();

      // new key, encrypt: 63-cycle latency, ascending indices
      accept(1'b1, 1'b0);
      drain();
      chk("key_ok_after_exp", 32'(key_ok), 32'd1);

      // cached key, decrypt: 34-cycle latency, descending indices
      accept(1'b0, 1'b1);
      drain();

      // abort in the 10th KEXP cycle
      accept(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step();
      chk("abort_in_kexp", 32'(kExp), 32'd1);
      chk("abort_kexp_idx", 32'(count), 32'(M + 9));
      abort = 1'b1;
      exp_q.delete();
      m_key_ok = 1'b0;
      push_idle();
      step();
      abort = 1'b0;
      push_idle();
      step();
      chk("abort_key_ok", 32'(key_ok), 32'd0);
      accept(1'b0, 1'b0);
      drain();

      // start held high across a full run and the following idle cycle
      start = 1'b1; new_key = 1'b0; enc_dec = 1'b0;
      push_op(1'b0, 1'b0);
      cyc = 0;
      step();
      drain();
      push_op(1'b0, 1'b0);
      cyc = 0;
      step();
      start = 1'b0;
      drain();
      push_idle();
      step();
      push_idle();
      step();

      // reset pulse in ROUND at index 15
      accept(1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step();
      chk("pre_reset_round", 32'({rnd_en, count}), 32'({1'b1, 5'd15}));
      nReset = 1'b1;
      #1;
      chk("reset_mid_round", 32'(obs()), 32'(vec(1, 0, 0, 0, 0, 0, 0, 0, 0)));
      exp_q.delete();
      m_key_ok = 1'b0;
      m_dir = 1'b0;
      #2;
      nReset = 1'b0;
      push_idle();
      step();
      accept(1'b0, 1'b1);
      drain();

      // abort and start together in IDLE
      start = 1'b1; abort = 1'b1; new_key = 1'b1;
      push_idle();
      push_idle();
      step();
      step();
      start = 1'b0; abort = 1'b0; new_key = 1'b0;
      chk("abort_start_idle", 32'(ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/simon_sched_ctrl.md
SIMON_SCHED_CTRL -- requirements
Module: simon_sched_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N  16  word width
  M  4   key words
  T  32  rounds
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk      in   1          sole clock, rising edge
  nReset   in   1          asynchronous, active-high reset (1 = reset)
  start    in   1          operation request, accepted only while ready=1
  enc_dec  in   1          0 = encrypt, 1 = decrypt; sampled with accepted start
  new_key  in   1          1 = reload and re-expand key; sampled with accepted start
  abort    in   1          cancel current operation
  ready    out  1          controller idle, start accepted
  kLd      out  1          load M key words into key schedule
  kExp     out  1          compute one expanded key word
  pLd      out  1          load plaintext/ciphertext into round datapath
  rnd_en   out  1          execute one round
  dir      out  1          latched enc_dec
  count    out  $clog2(T)  key-expansion or round index
  done     out  1          one-cycle completion pulse
  key_ok   out  1          expanded key schedule valid

Function
REQ-003 The FSM SHALL have states IDLE, KLOAD, KEXP, PLOAD, ROUND, DONE.
REQ-004 In IDLE, ready SHALL be 1; in all other states, ready SHALL be 0.
REQ-005 A start sampled high in IDLE with abort low SHALL latch enc_dec into dir and leave IDLE on that edge.
REQ-006 On leaving IDLE, the next state SHALL be KLOAD if new_key=1 or key_ok=0, else PLOAD.
REQ-007 KLOAD SHALL last 1 cycle with kLd=1, and SHALL clear key_ok.
REQ-008 KEXP SHALL last T-M cycles with kExp=1 and count stepping M, M+1, ..., T-1.
REQ-009 key_ok SHALL be set on the edge leaving KEXP.
REQ-010 PLOAD SHALL last 1 cycle with pLd=1.
REQ-011 ROUND SHALL last T cycles with rnd_en=1.
REQ-012 In ROUND, count SHALL step 0..T-1 when dir=0 and T-1..0 when dir=1.
REQ-013 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-014 Latency, with start accepted at edge k:
  cached key: done high in cycle k+T+2 (k+34 at defaults).
  new key: done high in cycle k+2T-M+3 (k+63 at defaults).
REQ-015 kLd, kExp, pLd, rnd_en and done SHALL be mutually exclusive.
REQ-016 In IDLE, PLOAD and DONE, count SHALL be 0.
REQ-017 count SHALL never exceed T-1, with no wrap-around during a phase.
REQ-018 start while ready=0 SHALL be ignored: not queued, and enc_dec/new_key not sampled.
REQ-019 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with all strobes low and no done pulse.
REQ-020 abort received in KLOAD or KEXP SHALL leave key_ok=0.
REQ-021 abort and start both high in IDLE: abort SHALL win and start SHALL be ignored.
REQ-022 start high in the DONE cycle SHALL be ignored; back-to-back operations SHALL see one IDLE cycle between them.
REQ-023 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-024 nReset=1 SHALL immediately force IDLE, count=0, dir=0 and key_ok=0, with all strobes and done at 0; ready=1 follows from IDLE.
REQ-025 Reset mid-operation SHALL discard the operation without a done pulse; the next operation SHALL re-expand the key.
REQ-026 Deassertion of nReset SHALL take effect on the following clk edge without glitching outputs.

Structure
REQ-027 Package simon_pkg SHALL hold N, M, T, COUNT_W = $clog2(T) and the state enum type.
REQ-028 simon_sched_ctrl SHALL be a single module with the counter inline; no sub-module.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  - reset, then start with enc_dec=0, new_key=1 -> kLd 1 cycle, kExp 28 cycles (count 4..31), pLd, rnd_en 32 cycles (count 0..31), done at k+63, key_ok=1.
  - next start with new_key=0, enc_dec=1 -> no kLd/kExp, pLd, rnd_en with count 31..0, done at k+34.
  - abort at the 10th KEXP cycle -> IDLE next edge, key_ok=0, no done; next start with new_key=0 still performs KLOAD.
  - start held high throughout a run -> exactly one operation; a new acceptance only once ready=1 again.
  - nReset pulse during ROUND (count=15) -> all outputs 0, ready=1, key_ok=0 immediately.
  - abort and start high together in IDLE -> remains IDLE, ready=1.
